// File: rtl/lfsr_counter_param.sv
// rtl/lfsr_counter_param.sv - parametrised Fibonacci LFSR counter with free-run, stop and reload modes
// Optional binary step counter output 'steps' is present when LFSR_STEP_COUNT_EN is defined.
module lfsr_counter_param #(
   parameter int unsigned      WIDTH = 6,
   parameter logic [WIDTH-1:0] TAPS  = 6'h30,
   parameter logic [WIDTH-1:0] SEED  = 6'h01
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cen,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] count_to,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] q,
   output logic             match,
   output logic             done,
   output logic             wrap,
`ifdef LFSR_STEP_COUNT_EN
   output logic [WIDTH-1:0] steps,
`endif
   output logic             zero_err
);

   typedef enum logic [1:0] {
      MODE_FREE     = 2'b00,
      MODE_STOP     = 2'b01,
      MODE_RELOAD   = 2'b10,
      MODE_FREE_ALT = 2'b11
   } mode_e;

   logic [WIDTH-1:0] r_q;
   logic             r_done;
   logic             r_wrap;
   logic             r_zero_err;

   mode_e            w_mode;
   logic             w_match;
   logic             w_fb;
   logic [WIDTH-1:0] w_step_raw;
   logic [WIDTH-1:0] w_step;
   logic             w_data_zero;
   logic [WIDTH-1:0] w_data_sub;
   logic             w_stop_hit;
   logic             w_reload_hit;

   assign w_mode       = mode_e'(mode);
   assign w_match      = (r_q == count_to);
   assign w_fb         = ^(r_q & TAPS);
   assign w_step_raw   = {r_q[WIDTH-2:0], w_fb};
   // Every value entering the state register is forced nonzero so the LFSR cannot lock up.
   assign w_step       = (w_step_raw == '0) ? SEED : w_step_raw;
   assign w_data_zero  = (data == '0);
   assign w_data_sub   = w_data_zero ? SEED : data;
   assign w_stop_hit   = w_match && (w_mode == MODE_STOP);
   assign w_reload_hit = w_match && (w_mode == MODE_RELOAD);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q        <= SEED;
         r_done     <= 1'b0;
         r_wrap     <= 1'b0;
         r_zero_err <= 1'b0;
      end else if (load) begin
         r_q        <= w_data_sub;
         r_zero_err <= w_data_zero;
         r_done     <= 1'b0;
         r_wrap     <= 1'b0;
      end else if (cen) begin
         r_wrap <= 1'b0;
         if (w_stop_hit) begin
            r_done <= 1'b1;
         end else if (w_reload_hit) begin
            r_q    <= w_data_sub;
            r_wrap <= 1'b1;
            if (w_data_zero) begin
               r_zero_err <= 1'b1;
            end
         end else begin
            r_q <= w_step;
         end
      end else begin
         r_wrap <= 1'b0;
      end
   end

`ifdef LFSR_STEP_COUNT_EN
   logic [WIDTH-1:0] r_steps;
   logic             w_steps_clr;
   logic             w_steps_inc;

   assign w_steps_clr = reset || load || (cen && w_reload_hit);
   assign w_steps_inc = cen && !w_stop_hit && !w_reload_hit;

   always_ff @(posedge clk) begin
      if (w_steps_clr) begin
         r_steps <= '0;
      end else if (w_steps_inc) begin
         r_steps <= r_steps + 1'b1;
      end
   end

   assign steps = r_steps;
`endif

   assign q        = r_q;
   assign match    = w_match;
   assign done     = r_done;
   assign wrap     = r_wrap;
   assign zero_err = r_zero_err;

endmodule

// File: tb/tb_lfsr_counter_param.sv
// tb/tb_lfsr_counter_param.sv - scoreboard bench for lfsr_counter_param
module tb_lfsr_counter_param;

   localparam int          W    = 6;
   localparam logic [W-1:0] TAPS = 6'h30;
   localparam logic [W-1:0] SEED = 6'h01;

   logic         clk = 1'b0;
   logic         reset, cen, load;
   logic [W-1:0] data, count_to, q;
   logic [1:0]   mode;
   logic         match, done, wrap, zero_err;
`ifdef LFSR_STEP_COUNT_EN
   logic [W-1:0] steps;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [W-1:0] q;
      logic         match;
      logic         done;
      logic         wrap;
      logic         zerr;
      logic [W-1:0] steps;
   } exp_t;

   exp_t exp_q[$];

   lfsr_counter_param #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED)) dut (
      .clk      (clk),
      .reset    (reset),
      .cen      (cen),
      .load     (load),
      .data     (data),
      .count_to (count_to),
      .mode     (mode),
      .q        (q),
      .match    (match),
      .done     (done),
      .wrap     (wrap),
`ifdef LFSR_STEP_COUNT_EN
      .steps    (steps),
`endif
      .zero_err (zero_err)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [W-1:0] eq, input logic em, input logic ed,
                               input logic ew, input logic ez, input logic [W-1:0] es);
      exp_t e;
      e.q = eq; e.match = em; e.done = ed; e.wrap = ew; e.zerr = ez;
`ifdef LFSR_STEP_COUNT_EN
      e.steps = es;
`else
      e.steps = es & '0;
`endif
      return e;
   endfunction

   function automatic exp_t get_obs();
      exp_t o;
      o.q = q; o.match = match; o.done = done; o.wrap = wrap; o.zerr = zero_err;
`ifdef LFSR_STEP_COUNT_EN
      o.steps = steps;
`else
      o.steps = '0;
`endif
      return o;
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("q=%h match=%b done=%b wrap=%b zero_err=%b steps=%0d",
                       e.q, e.match, e.done, e.wrap, e.zerr, e.steps);
   endfunction

   // Reference successor, written bitwise from the tap mask.
   function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
      logic         fb;
      logic [W-1:0] n;
      fb = 1'b0;
      for (int i = 0; i < W; i++) if (TAPS[i]) fb = fb ^ s[i];
      n = {s[W-2:0], fb};
      if (n == '0) n = SEED;
      return n;
   endfunction

   task automatic drive(input logic r, input logic l, input logic c,
                        input logic [W-1:0] d, input logic [W-1:0] ct, input logic [1:0] md);
      @(negedge clk);
      reset = r; load = l; cen = c; data = d; count_to = ct; mode = md;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e, o;
      exp_q.push_back(mk(6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(1, 0, 0, 6'h00, 6'h10, 2'b00);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset: got %s, want %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(1, 1, 1, 6'h2A, 6'h10, 2'b00);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_over_load: got %s, want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_free_run();
      logic [W-1:0] seq [7] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03, 6'h06};
      exp_t e, o;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(mk(seq[i], seq[i] == 6'h10, 1'b0, 1'b0, 1'b0, W'(i + 1)));
         drive(0, 0, 1, 6'h00, 6'h10, 2'b00);
         e = exp_q.pop_front(); o = get_obs(); checks++;
         if (o !== e) begin errors++; $display("FAIL free_run[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_load();
      logic [W-1:0] seq [3] = '{6'h16, 6'h2D, 6'h1B};
      exp_t e, o;
      exp_q.push_back(mk(6'h0B, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(0, 1, 0, 6'h0B, 6'h10, 2'b00);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL load: got %s, want %s", fmt(o), fmt(e)); end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(seq[i], 1'b0, 1'b0, 1'b0, 1'b0, W'(i + 1)));
         drive(0, 0, 1, 6'h0B, 6'h10, 2'b00);
         e = exp_q.pop_front(); o = get_obs(); checks++;
         if (o !== e) begin errors++; $display("FAIL load_step[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_stop();
      logic [W-1:0] seq [4] = '{6'h02, 6'h04, 6'h08, 6'h10};
      exp_t e, o;
      drive(1, 0, 0, 6'h00, 6'h10, 2'b01);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk(seq[i], seq[i] == 6'h10, 1'b0, 1'b0, 1'b0, W'(i + 1)));
         drive(0, 0, 1, 6'h0B, 6'h10, 2'b01);
         e = exp_q.pop_front(); o = get_obs(); checks++;
         if (o !== e) begin errors++; $display("FAIL stop_run[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      end
      for (int i = 0; i < 11; i++) begin
         exp_q.push_back(mk(6'h10, 1'b1, 1'b1, 1'b0, 1'b0, 6'd4));
         drive(0, 0, 1, 6'h0B, 6'h10, 2'b01);
         e = exp_q.pop_front(); o = get_obs(); checks++;
         if (o !== e) begin errors++; $display("FAIL stop_hold[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      end
      exp_q.push_back(mk(6'h0B, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(0, 1, 1, 6'h0B, 6'h10, 2'b01);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL stop_load_clear: got %s, want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_reload();
      logic [W-1:0] seq [6] = '{6'h16, 6'h2D, 6'h0B, 6'h16, 6'h2D, 6'h0B};
      logic [W-1:0] stp [6] = '{6'd1, 6'd2, 6'd0, 6'd1, 6'd2, 6'd0};
      exp_t e, o;
      exp_q.push_back(mk(6'h0B, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(0, 1, 0, 6'h0B, 6'h2D, 2'b10);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL reload_load: got %s, want %s", fmt(o), fmt(e)); end
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(mk(seq[i], seq[i] == 6'h2D, 1'b0, seq[i] == 6'h0B, 1'b0, stp[i]));
         drive(0, 0, 1, 6'h0B, 6'h2D, 2'b10);
         e = exp_q.pop_front(); o = get_obs(); checks++;
         if (o !== e) begin errors++; $display("FAIL reload[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      end
      exp_q.push_back(mk(6'h0B, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(0, 0, 0, 6'h0B, 6'h2D, 2'b10);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL reload_hold: got %s, want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_zero_load();
      exp_t e, o;
      exp_q.push_back(mk(6'h01, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
      drive(0, 1, 0, 6'h00, 6'h10, 2'b00);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL zero_load: got %s, want %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(6'h02, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1));
      drive(0, 0, 1, 6'h00, 6'h10, 2'b00);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL zero_sticky: got %s, want %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(6'h05, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(0, 1, 0, 6'h05, 6'h05, 2'b10);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL nonzero_load: got %s, want %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(6'h01, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0));
      drive(0, 0, 1, 6'h00, 6'h05, 2'b10);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL zero_reload: got %s, want %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(6'h02, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1));
      drive(0, 0, 1, 6'h00, 6'h05, 2'b00);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL zero_reload_after: got %s, want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_reset_mid();
      exp_t e, o;
      drive(0, 1, 0, 6'h00, 6'h10, 2'b01);
      for (int i = 0; i < 4; i++) drive(0, 0, 1, 6'h00, 6'h10, 2'b01);
      exp_q.push_back(mk(6'h10, 1'b1, 1'b1, 1'b0, 1'b1, 6'd4));
      drive(0, 0, 1, 6'h00, 6'h10, 2'b01);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_done: got %s, want %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(1, 0, 1, 6'h00, 6'h10, 2'b01);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_reset: got %s, want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_load_priority();
      exp_t e, o;
      exp_q.push_back(mk(6'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
      drive(0, 1, 1, 6'h2A, 6'h01, 2'b10);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL load_over_cen: got %s, want %s", fmt(o), fmt(e)); end
      exp_q.push_back(mk(6'h15, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1));
      drive(0, 0, 1, 6'h00, 6'h15, 2'b11);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL mode11_step: got %s, want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_unreachable();
      exp_t e, o;
      drive(1, 0, 0, 6'h00, 6'h00, 2'b01);
      for (int i = 0; i < 62; i++) drive(0, 0, 1, 6'h00, 6'h00, 2'b01);
      exp_q.push_back(mk(6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 6'd63));
      drive(0, 0, 1, 6'h00, 6'h00, 2'b01);
      e = exp_q.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL unreachable_period: got %s, want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] m_q, m_s, d, ct;
      logic         m_done, m_wrap, m_zerr, r, l, c, hit;
      logic [1:0]   md;
      exp_t         e, o;
      m_q = SEED; m_s = '0; m_done = 0; m_wrap = 0; m_zerr = 0;
      drive(1, 0, 0, 6'h00, 6'h00, 2'b00);
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 59) == 0);
         l  = ($urandom_range(0, 15) == 0);
         c  = ($urandom_range(0, 3) != 0);
         d  = ($urandom_range(0, 5) == 0) ? 6'h00 : W'($urandom);
         ct = ($urandom_range(0, 2) == 0) ? m_q : W'($urandom);
         md = 2'($urandom);
         hit = (m_q == ct);
         if (r) begin
            m_q = SEED; m_s = '0; m_done = 0; m_wrap = 0; m_zerr = 0;
         end else if (l) begin
            m_q = (d == 0) ? SEED : d; m_zerr = (d == 0); m_s = '0; m_done = 0; m_wrap = 0;
         end else if (c) begin
            m_wrap = 0;
            if (md == 2'b01 && hit) m_done = 1;
            else if (md == 2'b10 && hit) begin
               m_q = (d == 0) ? SEED : d; m_wrap = 1; m_s = '0;
               if (d == 0) m_zerr = 1;
            end else begin
               m_q = ref_step(m_q); m_s = m_s + 1'b1;
            end
         end else m_wrap = 0;
         exp_q.push_back(mk(m_q, m_q == ct, m_done, m_wrap, m_zerr, m_s));
         drive(r, l, c, d, ct, md);
         e = exp_q.pop_front(); o = get_obs(); checks++;
         if (o !== e) begin errors++; $display("FAIL random[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      end
   endtask

   initial begin
      reset = 1; load = 0; cen = 0; data = '0; count_to = '0; mode = 2'b00;
      test_reset();
      test_free_run();
      test_load();
      test_stop();
      test_reload();
      test_zero_load();
      test_reset_mid();
      test_load_priority();
      test_unreachable();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
